// File: rtl/rv32_dmem_if.sv
// Load/store bus between the rv32 core (master) and its data-memory responder (slave).
// Latency: none, this is wiring only.
// Backpressure: req_ready stalls requests and rsp_ready stalls responses.
interface rv32_dmem_if #(
   parameter int AW = 32
);
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [1:0]    req_size;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_rdata;
   logic          rsp_error;

   modport master (
      output req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error
   );

   modport slave (
      input  req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_error
   );
endinterface

// File: rtl/rv32_dmem_responder.sv
// Byte/half/word load-store responder over a word-organised array; word-crossing accesses are split in two.
// Latency: response 1 cycle after accept, or 2 cycles for a split access; errors always take 1 cycle.
// Backpressure: one request in flight; req_ready is low until the response is taken with rsp_ready.
module rv32_dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 32
) (
   input  logic        clk,
   input  logic        reset,
   rv32_dmem_if.slave  bus
);

   localparam int            IW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [AW-2:0] DEPTH_L = (AW-1)'(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, SECOND, RESP} state_t;

   // storage, deliberately not reset
   logic [31:0] mem [DEPTH_WORDS];

   // registered state
   state_t      state_q,   state_d;
   logic [1:0]  off_q,     off_d;
   logic [1:0]  size_q,    size_d;
   logic        write_q,   write_d;
   logic [IW-1:0] w1_q,    w1_d;
   logic [3:0]  be_hi_q,   be_hi_d;
   logic [31:0] wdat_hi_q, wdat_hi_d;
   logic [31:0] lo_word_q, lo_word_d;
   logic [31:0] rdata_q,   rdata_d;
   logic        error_q,   error_d;

   // request decode
   logic [1:0]    off;
   logic [AW-2:0] w0_full;
   logic [AW-2:0] w1_full;
   logic [3:0]    mask;
   logic [7:0]    be8;
   logic [63:0]   wd64;
   logic          split;
   logic          acc_err;

   // array port
   logic [IW-1:0] rd_idx;
   logic [31:0]   rd_word;
   logic          wr_en;
   logic [IW-1:0] wr_idx;
   logic [3:0]    wr_be;
   logic [31:0]   wr_dat;

   // Right-align the addressed bytes of {word1,word0} and zero-extend to the access size.
   function automatic logic [31:0] load_fmt(input logic [63:0] r64,
                                            input logic [1:0]  offs,
                                            input logic [1:0]  sz);
      logic [31:0] s;
      s = 32'(r64 >> {offs, 3'b000});
      case (sz)
         2'b00:   load_fmt = {24'b0, s[7:0]};
         2'b01:   load_fmt = {16'b0, s[15:0]};
         default: load_fmt = s;
      endcase
   endfunction

   // Decode the incoming request: word indices, lane enables, shifted data, split and error.
   always_comb begin
      off     = bus.req_addr[1:0];
      w0_full = {1'b0, bus.req_addr[AW-1:2]};
      // one extra bit so a wrap past the top of the address space lands out of range
      w1_full = w0_full + (AW-1)'(1);
      case (bus.req_size)
         2'b00:   mask = 4'b0001;
         2'b01:   mask = 4'b0011;
         default: mask = 4'b1111;
      endcase
      be8     = {4'b0000, mask} << off;
      wd64    = {32'b0, bus.req_wdata} << {off, 3'b000};
      split   = ((bus.req_size == 2'b01) && (off == 2'd3)) ||
                ((bus.req_size == 2'b10) && (off != 2'd0));
      acc_err = (bus.req_size == 2'b11) || (w0_full >= DEPTH_L) ||
                (split && (w1_full >= DEPTH_L));
   end

   assign rd_word = mem[rd_idx];

   // Next-state and array control: accept cycle handles word 0, SECOND handles word 1.
   always_comb begin
      state_d   = state_q;
      off_d     = off_q;
      size_d    = size_q;
      write_d   = write_q;
      w1_d      = w1_q;
      be_hi_d   = be_hi_q;
      wdat_hi_d = wdat_hi_q;
      lo_word_d = lo_word_q;
      rdata_d   = rdata_q;
      error_d   = error_q;
      rd_idx    = w0_full[IW-1:0];
      wr_en     = 1'b0;
      wr_idx    = w0_full[IW-1:0];
      wr_be     = 4'b0000;
      wr_dat    = 32'b0;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               off_d     = off;
               size_d    = bus.req_size;
               write_d   = bus.req_write;
               w1_d      = w1_full[IW-1:0];
               be_hi_d   = be8[7:4];
               wdat_hi_d = wd64[63:32];
               lo_word_d = rd_word;
               if (acc_err) begin
                  error_d = 1'b1;
                  rdata_d = 32'b0;
                  state_d = RESP;
               end else begin
                  error_d = 1'b0;
                  if (bus.req_write) begin
                     wr_en   = 1'b1;
                     wr_be   = be8[3:0];
                     wr_dat  = wd64[31:0];
                     rdata_d = 32'b0;
                  end else begin
                     rdata_d = load_fmt({32'b0, rd_word}, off, bus.req_size);
                  end
                  state_d = split ? SECOND : RESP;
               end
            end
         end
         SECOND: begin
            rd_idx = w1_q;
            wr_idx = w1_q;
            if (write_q) begin
               wr_en   = 1'b1;
               wr_be   = be_hi_q;
               wr_dat  = wdat_hi_q;
               rdata_d = 32'b0;
            end else begin
               rdata_d = load_fmt({rd_word, lo_word_q}, off_q, size_q);
            end
            state_d = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and captured-request registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         off_q     <= 2'b0;
         size_q    <= 2'b0;
         write_q   <= 1'b0;
         w1_q      <= '0;
         be_hi_q   <= 4'b0;
         wdat_hi_q <= 32'b0;
         lo_word_q <= 32'b0;
         rdata_q   <= 32'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         off_q     <= off_d;
         size_q    <= size_d;
         write_q   <= write_d;
         w1_q      <= w1_d;
         be_hi_q   <= be_hi_d;
         wdat_hi_q <= wdat_hi_d;
         lo_word_q <= lo_word_d;
         rdata_q   <= rdata_d;
         error_q   <= error_d;
      end
   end

   // Byte-lane writes into the array.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
               mem[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
            end
         end
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_error = error_q;

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Directed bench for rv32_dmem_responder with a response scoreboard.
// Latency: checks 1-cycle (non-split/error) and 2-cycle (split) response timing.
// Backpressure: holds rsp_ready low and checks held outputs and req_ready.
module tb_rv32_dmem_responder;

   logic clk;
   logic reset;

   rv32_dmem_if #(.AW(32)) bus ();

   rv32_dmem_responder #(.DEPTH_WORDS(1024), .AW(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] d;
      logic        e;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %h, expected %h", nm, act, req);
   endtask

   // monitor: every accepted response is compared with the oldest expectation
   always @(negedge clk) begin
      if (!reset && bus.rsp_valid && bus.rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            exp_t x;
            x = exp_q.pop_front();
            chk("rsp_rdata", bus.rsp_rdata, x.d);
            chk("rsp_error", {31'b0, bus.rsp_error}, {31'b0, x.e});
         end
      end
   end

   // drive one request, wait for accept, check response latency
   task automatic send(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                       input int lat, input bit push);
      int n;
      exp_t x;
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_size  = sz;
      bus.req_addr  = a;
      bus.req_wdata = wd;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("req_ready_timeout", 32'd1, 32'd0);
      if (push) begin
         x.d = ed;
         x.e = ee;
         exp_q.push_back(x);
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      n = 1;
      @(negedge clk);
      while (!bus.rsp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("latency@%h", a), n, lat);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (bus.rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("drain_timeout", 32'd1, 32'd0);
   endtask

   task automatic op(input logic w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] ed, input logic ee, input int lat);
      send(w, sz, a, wd, ed, ee, lat, 1'b1);
      drain();
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
      chk({nm, "_rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
      chk({nm, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
      chk({nm, "_rsp_error"}, {31'b0, bus.rsp_error}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_size  = 2'b00;
      bus.req_addr  = 32'b0;
      bus.req_wdata = 32'b0;
      bus.rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      @(posedge clk); #1 reset = 1'b0;

      // word store then load
      op(1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1);
      op(0, 2'b10, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1);

      // byte lane merge
      op(1, 2'b10, 32'h10, 32'h11223344, 32'h0,        0, 1);
      op(1, 2'b00, 32'h11, 32'h000000A5, 32'h0,        0, 1);
      op(0, 2'b00, 32'h11, 32'h0,        32'h000000A5, 0, 1);
      op(0, 2'b10, 32'h10, 32'h0,        32'h1122A544, 0, 1);
      op(0, 2'b01, 32'h12, 32'h0,        32'h00001122, 0, 1);

      // split word load and split half store
      op(1, 2'b10, 32'h20, 32'h44332211, 32'h0,        0, 1);
      op(1, 2'b10, 32'h24, 32'h88776655, 32'h0,        0, 1);
      op(1, 2'b10, 32'h28, 32'h12345678, 32'h0,        0, 1);
      op(0, 2'b10, 32'h23, 32'h0,        32'h77665544, 0, 2);
      op(0, 2'b00, 32'h23, 32'h0,        32'h00000044, 0, 1);
      op(0, 2'b01, 32'h22, 32'h0,        32'h00004433, 0, 1);
      op(1, 2'b01, 32'h27, 32'h0000BBAA, 32'h0,        0, 2);
      op(0, 2'b10, 32'h24, 32'h0,        32'hAA776655, 0, 1);
      op(0, 2'b10, 32'h28, 32'h0,        32'h123456BB, 0, 1);
      op(0, 2'b01, 32'h27, 32'h0,        32'h0000BBAA, 0, 2);

      // range and size errors
      op(0, 2'b10, 32'h1000, 32'h0,        32'h0,        1, 1);
      op(1, 2'b10, 32'hFFC,  32'hCAFEF00D, 32'h0,        0, 1);
      op(1, 2'b10, 32'hFFD,  32'h11111111, 32'h0,        1, 1);
      op(0, 2'b10, 32'hFFC,  32'h0,        32'hCAFEF00D, 0, 1);
      op(0, 2'b00, 32'hFFF,  32'h0,        32'h000000CA, 0, 1);
      op(0, 2'b11, 32'h10,   32'h0,        32'h0,        1, 1);
      op(1, 2'b11, 32'h10,   32'h55555555, 32'h0,        1, 1);
      op(0, 2'b10, 32'h10,   32'h0,        32'h1122A544, 0, 1);
      op(0, 2'b01, 32'hFFFFFFFF, 32'h0,    32'h0,        1, 1);

      // backpressure: outputs held while rsp_ready is low
      bus.rsp_ready = 1'b0;
      send(0, 2'b10, 32'h10, 32'h0, 32'h1122A544, 0, 1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
         chk("bp_rsp_rdata", bus.rsp_rdata, 32'h1122A544);
         chk("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
      end
      @(posedge clk); #1 bus.rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release_req_ready", {31'b0, bus.req_ready}, 32'd1);

      // reset while a response is waiting: response discarded
      bus.rsp_ready = 1'b0;
      send(0, 2'b10, 32'h10, 32'h0, 32'h0, 0, 1, 1'b0);
      reset = 1'b1;
      #1;
      chk_reset_vals("rst_in_resp");
      @(posedge clk); #1;
      reset         = 1'b0;
      bus.rsp_ready = 1'b1;

      // reset during SECOND of a split store
      op(1, 2'b10, 32'h30, 32'h0, 32'h0, 0, 1);
      op(1, 2'b10, 32'h34, 32'h0, 32'h0, 0, 1);
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_size  = 2'b10;
      bus.req_addr  = 32'h31;
      bus.req_wdata = 32'hA1B2C3D4;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("second_req_ready", {31'b0, bus.req_ready}, 32'd0);
      chk("second_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      reset = 1'b1;
      #1;
      chk_reset_vals("rst_in_second");
      @(posedge clk); #1 reset = 1'b0;
      op(0, 2'b10, 32'h30, 32'h0, 32'hB2C3D400, 0, 1);
      op(0, 2'b10, 32'h34, 32'h0, 32'h00000000, 0, 1);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
